// File: rtl/line_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_scan_ctrl
// Description : Walks the board rows bottom to top after a piece locks.
//               Requests each row from the VRAM row reader, flags rows whose
//               ten cells all differ from the background colour, and reports
//               a full-row mask, count, bottom-most full row and a running
//               line total.
// Revision    : 1.0 - initial release
// ============================================================================
module line_scan_ctrl #(
    parameter int          ROWS     = 20,
    parameter logic [15:0] BG_COLOR = 16'h000F,
    parameter int          TIMEOUT  = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            row_ready,
    input  logic [159:0]    read_reg,
    output logic [7:0]      row,
    output logic            row_ld,
    output logic            busy,
    output logic            done,
    output logic [ROWS-1:0] full_mask,
    output logic [4:0]      full_count,
    output logic [7:0]      lowest_full,
    output logic [15:0]     lines_total,
    output logic            err
);

    localparam logic [7:0]      c_LAST_ROW = 8'(ROWS - 1);
    localparam logic [7:0]      c_NO_ROW   = 8'hFF;
    localparam logic [ROWS-1:0] c_ROW_ONE  = ROWS'(1);
    localparam int              c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_row_ld;
    logic [9:0]          w_cell_set;
    logic                w_row_full;
    logic [7:0]          r_row;
    logic                r_busy;
    logic                r_done;
    logic [ROWS-1:0]     r_full_mask;
    logic [4:0]          r_full_count;
    logic [7:0]          r_lowest_full;
    logic [15:0]         r_lines_total;
    logic                r_err;
    logic [c_TMO_W-1:0]  r_tmo;

    // A cell counts as occupied when it differs from the background colour
    generate
        for (genvar c = 0; c < 10; c++) begin : g_cell
            assign w_cell_set[c] = (read_reg[16*c +: 16] != BG_COLOR);
        end
    endgenerate

    assign w_row_full = &w_cell_set;

    // Scan state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; row_ld drops combinationally the cycle row_ready arrives
    always_comb begin
        w_next   = r_state;
        w_row_ld = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                w_row_ld = ~row_ready;
                if (row_ready) begin
                    w_next = S_GAP;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_GAP: begin
                if (r_row == 8'd0) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Row pointer, result registers, line total and request timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row         <= c_LAST_ROW;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_full_mask   <= '0;
            r_full_count  <= 5'd0;
            r_lowest_full <= c_NO_ROW;
            r_lines_total <= 16'd0;
            r_err         <= 1'b0;
            r_tmo         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_full_mask   <= '0;
                        r_full_count  <= 5'd0;
                        r_err         <= 1'b0;
                        r_lowest_full <= c_NO_ROW;
                        r_row         <= c_LAST_ROW;
                        r_busy        <= 1'b1;
                        r_tmo         <= '0;
                    end
                end
                S_REQ: begin
                    if (row_ready) begin
                        r_tmo <= '0;
                        if (w_row_full) begin
                            r_full_mask  <= r_full_mask | (c_ROW_ONE << r_row);
                            r_full_count <= r_full_count + 5'd1;
                            if (r_lowest_full == c_NO_ROW) begin
                                r_lowest_full <= r_row;
                            end
                            if (r_lines_total != 16'hFFFF) begin
                                r_lines_total <= r_lines_total + 16'd1;
                            end
                        end
                    end else if (r_tmo == c_TMO_LAST) begin
                        // Reader stalled: abort, keeping the partial results
                        r_err  <= 1'b1;
                        r_tmo  <= '0;
                        r_done <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_row == 8'd0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_row <= r_row - 8'd1;
                    end
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                    r_row  <= c_LAST_ROW;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign row         = r_row;
    assign row_ld      = w_row_ld;
    assign busy        = r_busy;
    assign done        = r_done;
    assign full_mask   = r_full_mask;
    assign full_count  = r_full_count;
    assign lowest_full = r_lowest_full;
    assign lines_total = r_lines_total;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_line_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_scan_ctrl
// Description : Bench for line_scan_ctrl. A row-reader model answers each
//               request after 15 cycles from a board image; a scan-level
//               model predicts the result registers at each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_scan_ctrl;

    localparam int          ROWS  = 20;
    localparam logic [15:0] BG    = 16'h000F;
    localparam int          TMO   = 50000;
    localparam int          LAT_W = 13;

    logic            clk       = 1'b0;
    logic            reset     = 1'b0;
    logic            start     = 1'b0;
    logic            row_ready = 1'b0;
    logic [159:0]    read_reg  = '0;
    logic [7:0]      row;
    logic            row_ld;
    logic            busy;
    logic            done;
    logic [ROWS-1:0] full_mask;
    logic [4:0]      full_count;
    logic [7:0]      lowest_full;
    logic [15:0]     lines_total;
    logic            err;

    line_scan_ctrl #(.ROWS(ROWS), .BG_COLOR(BG), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .row_ready(row_ready),
        .read_reg(read_reg), .row(row), .row_ld(row_ld), .busy(busy),
        .done(done), .full_mask(full_mask), .full_count(full_count),
        .lowest_full(lowest_full), .lines_total(lines_total), .err(err)
    );

    always #5 clk = ~clk;

    // Board image and scenario controls
    logic [15:0] cells [ROWS][10];
    int dead_row = -1;
    int start_req = 0, start_ack = 0, swr_req = 0, swr_ack = 0;

    // Counters and reader state
    int n_checks = 0, n_fail = 0;
    int n_reqs = 0, scan_base = 0, done_cnt = 0, ld_run = 0, wcnt = 0, req_row = 0;
    bit active = 1'b0, dead_req = 1'b0;
    logic prev_rr = 1'b0, prev_ld = 1'b0, prev_done = 1'b0;
    logic [7:0] prev_row = 8'(ROWS - 1);

    // Scan-level expectations
    logic [ROWS-1:0] exp_mask = '0;
    int exp_count = 0, exp_reqs = 0;
    logic [7:0] exp_lowest = 8'hFF;
    logic [15:0] exp_lines = 16'd0;
    bit exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic fill_bg();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 10; c++) cells[r][c] = BG;
    endtask

    task automatic set_row(input int r, input logic [15:0] v);
        for (int c = 0; c < 10; c++) cells[r][c] = v;
    endtask

    // Predict a scan from the board image: rows bottom to top, stop at a dead row
    task automatic expect_scan();
        exp_mask = '0; exp_count = 0; exp_lowest = 8'hFF; exp_err = 1'b0; exp_reqs = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            bit f;
            exp_reqs++;
            if (r == dead_row) begin
                exp_err = 1'b1;
                break;
            end
            f = 1'b1;
            for (int c = 0; c < 10; c++) if (cells[r][c] == BG) f = 1'b0;
            if (f) begin
                exp_mask[r] = 1'b1;
                exp_count++;
                if (exp_lowest == 8'hFF) exp_lowest = 8'(r);
                if (exp_lines != 16'hFFFF) exp_lines = exp_lines + 16'd1;
            end
        end
    endtask

    // Reader model, input driver and per-cycle checker
    always @(negedge clk) begin
        if (!reset) begin
            start = 1'b0; row_ready = 1'b0; active = 1'b0;
            prev_rr = 1'b0; prev_ld = 1'b0; prev_done = 1'b0; prev_row = 8'(ROWS - 1);
            start_ack = start_req; swr_ack = swr_req;
        end else begin
            start = 1'b0;
            if (row_ready) begin
                row_ready = 1'b0;
            end else if (active && !dead_req) begin
                if (wcnt == 0) begin
                    row_ready = 1'b1;
                    for (int c = 0; c < 10; c++) read_reg[16*c +: 16] = cells[req_row][c];
                    if (swr_req != swr_ack) begin
                        start = 1'b1;
                        swr_ack = swr_req;
                    end
                end else begin
                    wcnt--;
                end
            end
            if (start_req != start_ack) begin
                start = 1'b1;
                start_ack = start_req;
            end
            #1;
            if (row_ready) chk("ld_drop_on_ready", 32'(row_ld), 32'd0);
            if (prev_rr) chk("gap_after_ready", 32'(row_ld), 32'd0);
            if (prev_ld && row_ld) chk("row_stable", 32'(row), 32'(prev_row));
            if (row_ld) chk("ld_only_busy", 32'(busy), 32'd1);
            if (prev_done) begin
                chk("done_one_cycle", 32'(done), 32'd0);
                chk("busy_after_done", 32'(busy), 32'd0);
            end
            if (busy && !done) chk("err_clear_in_scan", 32'(err), 32'd0);
            if (!busy) chk("idle_row", 32'(row), 32'(ROWS - 1));
            if (!row_ld) begin
                active = 1'b0;
            end else if (!active) begin
                active = 1'b1;
                req_row = int'(row);
                dead_req = (req_row == dead_row);
                wcnt = LAT_W;
                ld_run = 0;
                chk("req_order", 32'(row), 32'(ROWS - 1 - (n_reqs - scan_base)));
                n_reqs++;
            end
            if (row_ld) ld_run++;
            if (done) begin
                done_cnt++;
                chk("mask", 32'(full_mask), 32'(exp_mask));
                chk("count", 32'(full_count), 32'(exp_count));
                chk("lowest", 32'(lowest_full), 32'(exp_lowest));
                chk("lines", 32'(lines_total), 32'(exp_lines));
                chk("err", 32'(err), 32'(exp_err));
                chk("req_count", 32'(n_reqs - scan_base), 32'(exp_reqs));
                if (exp_err) chk("timeout_len", 32'(ld_run), 32'(TMO));
            end
            prev_rr = row_ready; prev_ld = row_ld; prev_done = done; prev_row = row;
        end
    end

    // Start a scan, optionally poke start mid-scan, wait (bounded) for done
    task automatic run_scan(input int budget, input int mid_at);
        int c0;
        bit got;
        c0 = done_cnt;
        scan_base = n_reqs;
        start_req++;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            #2;
            if (i == mid_at) start_req++;
            if (done_cnt != c0) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL scan_done: got no done pulse, want one within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
        #2;
        chk("single_done", 32'(done_cnt - c0), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row"}, 32'(row), 32'(ROWS - 1));
        chk({tag, "_row_ld"}, 32'(row_ld), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mask"}, 32'(full_mask), 32'd0);
        chk({tag, "_count"}, 32'(full_count), 32'd0);
        chk({tag, "_lowest"}, 32'(lowest_full), 32'hFF);
        chk({tag, "_lines"}, 32'(lines_total), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        bit hit;
        int c0;
        fill_bg();
        repeat (3) @(negedge clk);
        #2;
        chk_reset_vals("por");
        #1 reset = 1'b1;

        // Empty board
        expect_scan();
        run_scan(1000, -1);
        chk("empty_mask", 32'(full_mask), 32'h0);
        chk("empty_count", 32'(full_count), 32'd0);
        chk("empty_lowest", 32'(lowest_full), 32'hFF);
        chk("empty_err", 32'(err), 32'd0);

        // Rows 19 and 17 full; row 18 nearly full (cell 9 background)
        set_row(19, 16'h00F0);
        set_row(17, 16'h00F0);
        set_row(18, 16'h0F00);
        cells[18][9] = BG;
        expect_scan();
        run_scan(1000, -1);
        chk("two_mask", 32'(full_mask), 32'hA0000);
        chk("two_count", 32'(full_count), 32'd2);
        chk("two_lowest", 32'(lowest_full), 32'd19);
        chk("two_lines", 32'(lines_total), 32'd2);

        // Same board again, with a stray start mid-scan and one alongside row_ready
        expect_scan();
        swr_req++;
        run_scan(1000, 100);
        chk("again_mask", 32'(full_mask), 32'hA0000);
        chk("again_lines", 32'(lines_total), 32'd4);

        // Reader never answers row 12
        fill_bg();
        set_row(19, 16'h1234);
        set_row(15, 16'h1234);
        dead_row = 12;
        expect_scan();
        run_scan(60000, -1);
        dead_row = -1;
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_mask", 32'(full_mask), 32'h88000);
        chk("tmo_count", 32'(full_count), 32'd2);
        chk("tmo_lines", 32'(lines_total), 32'd6);

        // Next scan clears err
        fill_bg();
        expect_scan();
        run_scan(1000, -1);
        chk("post_tmo_err", 32'(err), 32'd0);
        chk("post_tmo_lines", 32'(lines_total), 32'd6);

        // Reset during the row-10 request
        set_row(19, 16'hAAAA);
        set_row(17, 16'hAAAA);
        set_row(5, 16'hAAAA);
        scan_base = n_reqs;
        c0 = done_cnt;
        start_req++;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            #2;
            if (row == 8'd10 && row_ld) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL row10_req: got no row-10 request, want one within 2000 cycles");
        end
        #1 reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_lines = 16'd0;
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        chk("midrst_no_done", 32'(done_cnt - c0), 32'd0);

        // Clean scan after reset
        expect_scan();
        run_scan(1000, -1);
        chk("clean_mask", 32'(full_mask), 32'hA0020);
        chk("clean_count", 32'(full_count), 32'd3);
        chk("clean_lines", 32'(lines_total), 32'd3);

        // Line total saturation
        @(negedge clk);
        force dut.r_lines_total = 16'hFFFE;
        @(negedge clk);
        release dut.r_lines_total;
        exp_lines = 16'hFFFE;
        #2;
        chk("preload", 32'(lines_total), 32'hFFFE);
        expect_scan();
        run_scan(1000, -1);
        chk("sat_lines", 32'(lines_total), 32'hFFFF);
        expect_scan();
        run_scan(1000, -1);
        chk("sat_hold", 32'(lines_total), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_scan_ctrl.md
Name: line_scan_ctrl

Overview:
Downstream consumer of the VRAM row-read stage. After a piece locks, it walks every board row from bottom (ROWS-1) to top (0). For each row it issues a row-load request, waits for row-ready, and checks whether all 10 cells differ from the background colour. It produces a full-row mask, a count, the bottom-most full row and a running line total for the line-clear and score logic.

Parameters:
ROWS, 20, board rows scanned (indices 0..ROWS-1, must be ≤ 255)
BG_COLOR, 16'h000F, background cell value written at VRAM init/clear
TIMEOUT, 50000, max cycles waiting for row_ready before abort

Ports:
clk  in  1  system clock
reset  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  one-cycle pulse: begin scan (piece locked)
row_ready  in  1  one-cycle pulse from row reader: read_reg valid this cycle
read_reg  in  16 x10  cell words of requested row
row  out  8  row index to read; stable while row_ld may be high
row_ld  out  1  row read request (level, see handshake)
busy  out  1  scan in progress
done  out  1  one-cycle pulse: scan finished (good or aborted)
full_mask  out  ROWS  bit r = row r full, valid from done until next start
full_count  out  5  number of full rows in last scan
lowest_full  out  8  highest-index full row, 8'hFF if none
lines_total  out  16  cumulative full rows, saturates at 16'hFFFF
err  out  1  sticky: last scan aborted by timeout; cleared on start

Behaviour:
- Reset (reset=0, async): state IDLE; row=ROWS-1; busy=0, done=0, full_mask=0, full_count=0, lowest_full=8'hFF, lines_total=0, err=0, timeout counter=0.
- States: IDLE, REQ, GAP, DONE.
- IDLE:
  - On start: clear full_mask, full_count and err; set lowest_full=8'hFF; row<=ROWS-1; busy<=1; go to REQ.
  - start while busy is ignored.
- REQ:
  - row_ld = (state==REQ) & ~row_ready, decoded combinationally. It drops in the same cycle row_ready is seen, so the reader's idle state never samples a stale request.
  - The timeout counter increments each REQ cycle.
  - When row_ready=1, sample read_reg that cycle. full = AND over c=0..9 of (read_reg[c] != BG_COLOR).
    - If full: full_mask[row]<=1; full_count+1; lowest_full<=row if lowest_full==8'hFF; lines_total+1 saturating.
    - Clear the timeout counter, then go to GAP.
  - If the counter reaches TIMEOUT-1 without row_ready: err<=1, go to DONE. full_mask and full_count keep their partial values.
- GAP: one idle cycle (row_ld=0) so the reader returns to idle.
  - If row==0, go to DONE.
  - Otherwise row<=row-1 and go to REQ.
- DONE: done=1 for exactly one cycle; busy<=0; row<=ROWS-1; go to IDLE.
- Latency: per row = reader latency + 1 (GAP). Total ≈ ROWS*(reader latency+1)+2 cycles.
- Simultaneous events:
  - start together with row_ready while busy: row_ready is processed and start is ignored.
  - row_ready in IDLE, GAP or DONE is ignored.
- Reset mid-scan: aborts immediately to reset values. No done pulse. lines_total is lost.
- Outputs other than row_ld are registered.

Test Plan:
- Reader model answers each row in 15 cycles; all cells 16'h000F; start -> 20 requests for rows 19..0 in order; done once; full_mask=0, full_count=0, lowest_full=8'hFF, err=0.
- Rows 19 and 17 all 16'h00F0, others background -> full_mask=20'hA0000, full_count=2, lowest_full=19, lines_total=2. A second identical scan gives lines_total=4.
- Row 18 all 16'h0F00 except cell 9=16'h000F -> bit 18 clear, full_count=0.
- Handshake: row_ld deasserts in the same cycle row_ready=1, stays low ≥1 cycle, and row changes only while row_ld=0. A start pulse mid-scan has no effect.
- Reader never responds to row 12 -> after 50000 REQ cycles: err=1, done pulse, busy=0. Bits from rows 19..13 are retained. The next start clears err.
- reset low during the row-10 request -> all outputs at reset values within the same cycle. A later start performs a full clean scan. Preload lines_total=16'hFFFE plus a 3-full scan -> 16'hFFFF.
